// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular FIFO with epoch filtering,
// branch flush and a saturating counter of discarded packets.
module fetch_decode_queue #(
    parameter int DEPTH      = 4,
    parameter int INSN_WIDTH = 64,
    parameter int PC_WIDTH   = 21
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [PC_WIDTH-1:0]      fetch_pc,
    input  logic [INSN_WIDTH-1:0]    fetch_insn,
    input  logic                     fetch_epoch,
    input  logic                     flush,
    input  logic                     flush_epoch,
    output logic                     decode_valid,
    input  logic                     decode_ready,
    output logic [PC_WIDTH-1:0]      decode_pc,
    output logic [INSN_WIDTH-1:0]    decode_insn,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = PC_WIDTH + INSN_WIDTH;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] hold_q;
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          cur_epoch;
    logic          push;
    logic          pop;
    logic          store;
    logic          drop;

    assign fetch_ready  = (count < (AW+1)'(DEPTH));
    assign decode_valid = (count != '0);
    assign push         = fetch_valid & fetch_ready;
    assign pop          = decode_valid & decode_ready;
    assign store        = push & ~flush & (fetch_epoch == cur_epoch);
    assign drop         = push & (flush | (fetch_epoch != cur_epoch));

    // While empty, present the last head seen rather than stale storage.
    assign head                     = decode_valid ? mem[rd_ptr] : hold_q;
    assign {decode_pc, decode_insn} = head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cur_epoch <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cur_epoch <= flush_epoch;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (store) begin
            mem[wr_ptr] <= {fetch_pc, fetch_insn};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         hold_q <= '0;
        else if (decode_valid) hold_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DEPTH=4): ordering, full/wrap,
// flush and epochs, streaming, async reset and drop counter saturation.
module tb_fetch_decode_queue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [20:0] fetch_pc;
    logic [63:0] fetch_insn;
    logic        fetch_epoch;
    logic        flush;
    logic        flush_epoch;
    logic        decode_valid;
    logic        decode_ready;
    logic [20:0] decode_pc;
    logic [63:0] decode_insn;
    logic [2:0]  count;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

    fetch_decode_queue #(.DEPTH(4), .INSN_WIDTH(64), .PC_WIDTH(21)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_insn(fetch_insn), .fetch_epoch(fetch_epoch),
        .flush(flush), .flush_epoch(flush_epoch),
        .decode_valid(decode_valid), .decode_ready(decode_ready),
        .decode_pc(decode_pc), .decode_insn(decode_insn),
        .count(count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [20:0] pc, input logic [63:0] insn, input logic ep);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_insn  = insn;
        fetch_epoch = ep;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; fetch_valid = 0; fetch_pc = '0; fetch_insn = '0; fetch_epoch = 0;
        flush = 0; flush_epoch = 0; decode_ready = 0;
        #2;
        checks++; if (decode_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", decode_valid); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fetch_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (decode_pc !== 21'd0 || decode_insn !== 64'd0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", decode_pc, decode_insn); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        offer(21'h100, 64'hA, 1'b0);
        tick();
        checks++; if (count !== 3'd1 || decode_pc !== 21'h100) begin errors++; $display("FAIL first_push got count=%0d pc=%h exp 1/100", count, decode_pc); end
        offer(21'h108, 64'hB, 1'b0);
        tick();
        fetch_valid = 0;
        checks++; if (count !== 3'd2 || decode_pc !== 21'h100 || decode_insn !== 64'hA) begin errors++; $display("FAIL basic_two got count=%0d pc=%h insn=%h exp 2/100/a", count, decode_pc, decode_insn); end
        decode_ready = 1;
        tick();
        checks++; if (decode_insn !== 64'hB || decode_pc !== 21'h108 || count !== 3'd1) begin errors++; $display("FAIL basic_pop1 got insn=%h count=%0d exp b/1", decode_insn, count); end
        tick();
        decode_ready = 0;
        checks++; if (count !== 3'd0 || decode_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got count=%0d valid=%b exp 0/0", count, decode_valid); end
        checks++; if (decode_insn !== 64'hB || decode_pc !== 21'h108) begin errors++; $display("FAIL empty_hold got %h/%h exp 108/b", decode_pc, decode_insn); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 4; i++) begin
            offer(21'h200 + 21'(i * 8), 64'h10 + 64'(i), 1'b0);
            tick();
        end
        checks++; if (count !== 3'd4 || fetch_ready !== 1'b0) begin errors++; $display("FAIL full got count=%0d ready=%b exp 4/0", count, fetch_ready); end
        offer(21'h220, 64'h14, 1'b0);
        tick();
        checks++; if (count !== 3'd4 || decode_insn !== 64'h10) begin errors++; $display("FAIL full_hold got count=%0d insn=%h exp 4/10", count, decode_insn); end
        decode_ready = 1;
        tick();
        decode_ready = 0;
        checks++; if (count !== 3'd3 || fetch_ready !== 1'b1 || decode_insn !== 64'h11) begin errors++; $display("FAIL no_refill got count=%0d ready=%b insn=%h exp 3/1/11", count, fetch_ready, decode_insn); end
        tick();
        fetch_valid = 0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fifth_accept got count=%0d exp 4", count); end
        decode_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (decode_insn !== 64'h11 + 64'(i) || decode_pc !== 21'h208 + 21'(i * 8)) begin errors++; $display("FAIL wrap_order[%0d] got %h/%h exp %h/%h", i, decode_pc, decode_insn, 21'h208 + 21'(i * 8), 64'h11 + 64'(i)); end
            tick();
        end
        decode_ready = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_drain got count=%0d exp 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            offer(21'h300 + 21'(i), 64'h20 + 64'(i), 1'b0);
            tick();
        end
        checks++; if (count !== 3'd3 || drop_count !== 16'd0) begin errors++; $display("FAIL pre_flush got count=%0d drop=%0d exp 3/0", count, drop_count); end
        offer(21'h3F0, 64'h2F, 1'b0);
        flush = 1; flush_epoch = 1;
        tick();
        flush = 0; flush_epoch = 0;
        checks++; if (count !== 3'd0 || drop_count !== 16'd1 || decode_valid !== 1'b0) begin errors++; $display("FAIL flush got count=%0d drop=%0d valid=%b exp 0/1/0", count, drop_count, decode_valid); end
        offer(21'h310, 64'h30, 1'b0);
        tick();
        checks++; if (count !== 3'd0 || drop_count !== 16'd2) begin errors++; $display("FAIL stale_drop got count=%0d drop=%0d exp 0/2", count, drop_count); end
        offer(21'h318, 64'h31, 1'b1);
        tick();
        fetch_valid = 0;
        checks++; if (count !== 3'd1 || decode_pc !== 21'h318 || drop_count !== 16'd2) begin errors++; $display("FAIL new_epoch got count=%0d pc=%h drop=%0d exp 1/318/2", count, decode_pc, drop_count); end
        decode_ready = 1;
        tick();
        decode_ready = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            offer(21'h400 + 21'(i * 8), 64'h300 + 64'(i), 1'b1);
            tick();
        end
        decode_ready = 1;
        for (int k = 0; k < 10; k++) begin
            offer(21'h410 + 21'(k * 8), 64'h302 + 64'(k), 1'b1);
            checks++; if (count !== 3'd2 || decode_insn !== 64'h300 + 64'(k)) begin errors++; $display("FAIL stream[%0d] got count=%0d insn=%h exp 2/%h", k, count, decode_insn, 64'h300 + 64'(k)); end
            tick();
        end
        fetch_valid = 0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (decode_insn !== 64'h30A + 64'(k)) begin errors++; $display("FAIL stream_tail[%0d] got %h exp %h", k, decode_insn, 64'h30A + 64'(k)); end
            tick();
        end
        decode_ready = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end got count=%0d exp 0", count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            offer(21'h500 + 21'(i), 64'h40 + 64'(i), 1'b1);
            tick();
        end
        fetch_valid = 0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_reset got count=%0d exp 3", count); end
        #2;
        reset_n = 0;
        #1;
        checks++; if (decode_valid !== 1'b0 || count !== 3'd0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL async_reset got valid=%b count=%0d ready=%b exp 0/0/1", decode_valid, count, fetch_ready); end
        checks++; if (drop_count !== 16'd0 || decode_insn !== 64'd0) begin errors++; $display("FAIL async_reset_clr got drop=%0d insn=%h exp 0/0", drop_count, decode_insn); end
        offer(21'h600, 64'h50, 1'b0);
        decode_ready = 1;
        tick();
        checks++; if (count !== 3'd0 || decode_valid !== 1'b0) begin errors++; $display("FAIL in_reset got count=%0d valid=%b exp 0/0", count, decode_valid); end
        decode_ready = 0;
        reset_n = 1;
        tick();
        fetch_valid = 0;
        checks++; if (count !== 3'd1 || decode_pc !== 21'h600) begin errors++; $display("FAIL post_reset_push got count=%0d pc=%h exp 1/600", count, decode_pc); end
        decode_ready = 1;
        tick();
        decode_ready = 0;
    endtask

    task automatic test_saturate();
        offer(21'h700, 64'h60, 1'b1);
        repeat (65534) tick();
        checks++; if (drop_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp fffe", drop_count); end
        tick();
        checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hit got %h exp ffff", drop_count); end
        repeat (5) tick();
        fetch_valid = 0;
        checks++; if (drop_count !== 16'hFFFF || count !== 3'd0) begin errors++; $display("FAIL sat_hold got drop=%h count=%0d exp ffff/0", drop_count, count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
